// File: rtl/proc_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : proc_datapath
//  Description : Execution datapath driven by the control unit's per-cycle
//                control word. Holds a 16x16 register file with two
//                combinational read ports, a 256x16 synchronous data memory
//                (1-cycle read latency, old-data on read-during-write) and an
//                8-function combinational ALU. ALU operands, result and the
//                zero flag are exported for display.
//  Revision    : 1.0 - initial release
// ============================================================================
module proc_datapath #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4,
    parameter int DM_AW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic              D_Wr,
    input  logic              RF_s,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_W_Addr,
    input  logic [RF_AW-1:0]  RF_Ra_Addr,
    input  logic [RF_AW-1:0]  RF_Rb_Addr,
    input  logic [2:0]        ALU_s,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [DATA_W-1:0] ALU_Q,
    output logic [DATA_W-1:0] D_Rdata,
    output logic [DATA_W-1:0] W_data,
    output logic              Zero
);

    localparam int RF_DEPTH = 2 ** RF_AW;
    localparam int DM_DEPTH = 2 ** DM_AW;

    localparam logic [DATA_W-1:0] c_one  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_zero = '0;

    localparam logic [2:0] c_alu_zero = 3'b000;
    localparam logic [2:0] c_alu_add  = 3'b001;
    localparam logic [2:0] c_alu_sub  = 3'b010;
    localparam logic [2:0] c_alu_pass = 3'b011;
    localparam logic [2:0] c_alu_xor  = 3'b100;
    localparam logic [2:0] c_alu_or   = 3'b101;
    localparam logic [2:0] c_alu_and  = 3'b110;
    localparam logic [2:0] c_alu_inc  = 3'b111;

    logic [DATA_W-1:0] r_rf  [RF_DEPTH];
    logic [DATA_W-1:0] r_mem [DM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_alu_q;
    logic [DATA_W-1:0] w_wb_data;

    // Combinational register-file reads; no bypass from the write port.
    assign w_rd_a = r_rf[RF_Ra_Addr];
    assign w_rd_b = r_rf[RF_Rb_Addr];

    // Register file: cleared by reset, otherwise written from the write-back mux.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_rf[i] <= c_zero;
            end
        end else if (RF_W_en) begin
            r_rf[RF_W_Addr] <= w_wb_data;
        end
    end

    // Data-memory array: not cleared, store suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && D_Wr) begin
            r_mem[D_Addr] <= w_rd_a;
        end
    end

    // Registered memory read; the array value sampled is the pre-edge contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= c_zero;
        end else begin
            r_rdata <= r_mem[D_Addr];
        end
    end

    // ALU function decode; all arithmetic wraps modulo 2^DATA_W.
    always_comb begin
        w_alu_q = c_zero;
        case (ALU_s)
            c_alu_zero: w_alu_q = c_zero;
            c_alu_add:  w_alu_q = w_rd_a + w_rd_b;
            c_alu_sub:  w_alu_q = w_rd_a - w_rd_b;
            c_alu_pass: w_alu_q = w_rd_a;
            c_alu_xor:  w_alu_q = w_rd_a ^ w_rd_b;
            c_alu_or:   w_alu_q = w_rd_a | w_rd_b;
            c_alu_and:  w_alu_q = w_rd_a & w_rd_b;
            c_alu_inc:  w_alu_q = w_rd_a + c_one;
            default:    w_alu_q = c_zero;
        endcase
    end

    // Write-back source: loaded memory word or ALU result.
    assign w_wb_data = RF_s ? r_rdata : w_alu_q;

    assign ALU_A   = w_rd_a;
    assign ALU_B   = w_rd_b;
    assign ALU_Q   = w_alu_q;
    assign D_Rdata = r_rdata;
    assign W_data  = w_wb_data;
    assign Zero    = (w_alu_q == c_zero);

endmodule
`default_nettype wire
